// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with a four-register bus window and a level/overrun/timeout interrupt.
// Optional idle-timeout logic is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int SYS_CLK_FREQ = 60000000,
  parameter int BAUD         = 9600
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_ferr_i,
  input  logic        csb_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] data_o,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overrun;
  logic [8:0]    thr;
  logic          lvl_en;

  logic rd_acc, wr_acc, empty, full, pop, push, flush, ovr_set, ovr_clr;
  logic [1:0] sel;

  assign sel     = addr_i[3:2];
  assign rd_acc  = !csb_i && wen_i;
  assign wr_acc  = !csb_i && !wen_i;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign flush   = wr_acc && sel == 2'd2 && wmask_i[3] && data_i[24];
  assign pop     = rd_acc && sel == 2'd0 && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push    = rx_valid_i && (!full || pop) && !flush;
  assign ovr_set = rx_valid_i && full && !pop && !flush;
  assign ovr_clr = wr_acc && sel == 2'd1 && wmask_i[2] && data_i[18];

  logic to_pend, to_en;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam longint unsigned TO_CYCLES = 64'd40 * 64'(SYS_CLK_FREQ) / 64'(BAUD);
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_idle;
  assign to_idle = !empty && !push && !pop && !flush;

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      to_cnt  <= '0;
      to_pend <= 1'b0;
      to_en   <= 1'b0;
    end else begin
      if (!to_idle) to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + TW'(1);
      // Pending is set on the idle cycle that completes TO_CYCLES of inactivity.
      if (pop || flush) to_pend <= 1'b0;
      else if (to_idle && to_cnt == TO_LAST) to_pend <= 1'b1;
      if (wr_acc && sel == 2'd2 && wmask_i[2]) to_en <= data_i[17];
    end
  end
`else
  assign to_pend = 1'b0;
  assign to_en   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{ferr: rx_ferr_i, data: rx_byte_i};
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      thr     <= 9'd1;
      lvl_en  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !push) count <= count - (AW+1)'(1);
      end
      overrun <= ovr_set || (overrun && !ovr_clr);
      if (wr_acc && sel == 2'd2) begin
        if (wmask_i[0]) thr[7:0] <= data_i[7:0];
        if (wmask_i[1]) thr[8]   <= data_i[8];
        if (wmask_i[2]) lvl_en   <= data_i[16];
      end
    end
  end

  logic irq_d;
  assign irq_d = (lvl_en && thr != 9'd0 && 9'(count) >= thr)
              || (to_en && to_pend)
              || (lvl_en && overrun);

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) irq_o <= 1'b0;
    else        irq_o <= irq_d;
  end

  always_comb begin
    data_o = 32'h0;
    if (!csb_i) begin
      unique case (sel)
        2'd0: data_o = empty ? 32'h8000_0000 : {23'h0, mem[rd_ptr]};
        2'd1: data_o = {12'h0, to_pend, overrun, full, empty, 7'h0, 9'(count)};
        2'd2: data_o = {7'h0, 1'b0, 6'h0, to_en, lvl_en, 7'h0, thr};
        default: data_o = 32'h0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, addr_i[1:0], data_i};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: scoreboard queue of pushed bytes checked on DATA reads.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int CLKF  = 2400;
  localparam int BAUD  = 96;
  localparam int TO    = 40 * CLKF / BAUD;  // 1000 cycles

  logic        clk_i = 1'b0, reset = 1'b0;
  logic        rx_valid_i = 1'b0, rx_ferr_i = 1'b0;
  logic [7:0]  rx_byte_i = '0;
  logic        csb_i = 1'b1, wen_i = 1'b1;
  logic [3:0]  addr_i = '0, wmask_i = '0;
  logic [31:0] data_i = '0, data_o;
  logic        irq_o;

  uart_rx_fifo #(.DEPTH(DEPTH), .SYS_CLK_FREQ(CLKF), .BAUD(BAUD)) dut (
    .clk_i(clk_i), .reset(reset), .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i),
    .rx_ferr_i(rx_ferr_i), .csb_i(csb_i), .wen_i(wen_i), .addr_i(addr_i),
    .data_i(data_i), .wmask_i(wmask_i), .data_o(data_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  logic [8:0]  sb[$];
  logic [31:0] q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic ovr, input logic pend);
    int n = sb.size();
    return {12'h0, pend, ovr, n == DEPTH, n == 0, 7'h0, 9'(n)};
  endfunction

  // One bus/rx cycle: drive at negedge, sample combinational read data, release after posedge.
  task automatic cyc(input logic cs, input logic we, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic rv, input logic [7:0] rb, input logic rf,
                     output logic [31:0] rq);
    @(negedge clk_i);
    csb_i = cs; wen_i = we; addr_i = a; data_i = d; wmask_i = m;
    rx_valid_i = rv; rx_byte_i = rb; rx_ferr_i = rf;
    #1 rq = data_o;
    @(posedge clk_i); #1;
    csb_i = 1'b1; wen_i = 1'b1; addr_i = '0; data_i = '0; wmask_i = '0; rx_valid_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic f);
    logic [31:0] rq;
    cyc(1'b1, 1'b1, 4'h0, 32'h0, 4'h0, 1'b1, b, f, rq);
    if (sb.size() < DEPTH) sb.push_back({f, b});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] rq;
    cyc(1'b0, 1'b0, a, d, m, 1'b0, 8'h0, 1'b0, rq);
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [31:0] rq);
    cyc(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, 8'h0, 1'b0, rq);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] rq, exp;
    exp = (sb.size() != 0) ? {23'h0, sb[0]} : 32'h8000_0000;
    rdreg(4'h0, rq);
    check(tag, rq, exp);
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic pushpop_chk(input string tag, input logic [7:0] b, input logic f);
    logic [31:0] rq, exp;
    exp = {23'h0, sb[0]};
    cyc(1'b0, 1'b1, 4'h0, 32'h0, 4'h0, 1'b1, b, f, rq);
    check(tag, rq, exp);
    void'(sb.pop_front());
    sb.push_back({f, b});
  endtask

  // Combinational register peek with no clock edge involved.
  task automatic peek(input logic [3:0] a, output logic [31:0] rq);
    csb_i = 1'b0; wen_i = 1'b1; addr_i = a;
    #1 rq = data_o;
    csb_i = 1'b1; addr_i = '0;
  endtask

  initial begin
    #1;
    check("reset_data_o", data_o, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    reset = 1'b1;

    rdreg(4'h4, q); check("reset_status", q, 32'h0001_0000);
    rdreg(4'h8, q); check("reset_ctrl", q, 32'h0000_0001);
    rdreg(4'hC, q); check("reg_c_zero", q, 32'h0);

    push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0);
    rdreg(4'h4, q); check("status_cnt3", q, st(1'b0, 1'b0));
    pop_chk("pop_41"); pop_chk("pop_42"); pop_chk("pop_43");
    pop_chk("pop_empty");
    rdreg(4'h4, q); check("status_after_drain", q, st(1'b0, 1'b0));

    push(8'h55, 1'b1);
    pop_chk("pop_ferr");

    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i), 1'(i % 3 == 0));
    push(8'hEE, 1'b0);
    rdreg(4'h4, q); check("status_full_ovr", q, 32'h0006_0010);
    check("irq_ovr_disabled", {31'h0, irq_o}, 32'h0);
    wr(4'h4, 32'h0004_0000, 4'b1011);
    rdreg(4'h4, q); check("ovr_clr_masked", q, 32'h0006_0010);
    wr(4'h4, 32'h0004_0000, 4'b0100);
    rdreg(4'h4, q); check("ovr_cleared", q, 32'h0002_0010);

    pushpop_chk("full_pushpop", 8'hA5, 1'b0);
    rdreg(4'h4, q); check("full_pushpop_status", q, st(1'b0, 1'b0));
    for (int i = 0; i < DEPTH; i++) pop_chk($sformatf("drain_%0d", i));
    pop_chk("drain_empty");

    push(8'h11, 1'b0);
    pushpop_chk("cnt1_pushpop", 8'h22, 1'b1);
    pop_chk("cnt1_newhead");

    wr(4'h8, 32'h0001_0004, 4'b0111);
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
    @(posedge clk_i); #1 check("lvl_irq_3", {31'h0, irq_o}, 32'h0);
    push(8'h04, 1'b0);
    check("lvl_irq_4_lag", {31'h0, irq_o}, 32'h0);
    @(posedge clk_i); #1 check("lvl_irq_4", {31'h0, irq_o}, 32'h1);
    pop_chk("lvl_pop");
    check("lvl_irq_pop_lag", {31'h0, irq_o}, 32'h1);
    @(posedge clk_i); #1 check("lvl_irq_pop", {31'h0, irq_o}, 32'h0);
    pop_chk("lvl_drain_a"); pop_chk("lvl_drain_b"); pop_chk("lvl_drain_c");

    wr(4'h8, 32'h0003_0008, 4'b0111);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    rdreg(4'h8, q); check("ctrl_to_en", q, 32'h0003_0008);
    push(8'h7E, 1'b0);
    repeat (TO - 1) @(posedge clk_i);
    #1 peek(4'h4, q); check("to_not_yet", q, st(1'b0, 1'b0));
    @(posedge clk_i); #1 peek(4'h4, q); check("to_pending", q, st(1'b0, 1'b1));
    check("to_irq_lag", {31'h0, irq_o}, 32'h0);
    @(posedge clk_i); #1 check("to_irq", {31'h0, irq_o}, 32'h1);
    pop_chk("to_pop");
    peek(4'h4, q); check("to_cleared", q, st(1'b0, 1'b0));
    @(posedge clk_i); #1 check("to_irq_clr", {31'h0, irq_o}, 32'h0);
`else
    rdreg(4'h8, q); check("ctrl_no_to", q, 32'h0001_0008);
    push(8'h7E, 1'b0);
    repeat (TO + 4) @(posedge clk_i);
    #1 peek(4'h4, q); check("no_to_status", q, st(1'b0, 1'b0));
    check("no_to_irq", {31'h0, irq_o}, 32'h0);
    pop_chk("no_to_pop");
`endif

    wr(4'h8, 32'h0000_0001, 4'b0111);
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0);
    cyc(1'b0, 1'b0, 4'h8, 32'h0100_0000, 4'b1000, 1'b1, 8'hFF, 1'b0, q);
    sb.delete();
    rdreg(4'h4, q); check("flush_status", q, 32'h0001_0000);
    rdreg(4'h8, q); check("flush_ctrl", q, 32'h0000_0001);
    pop_chk("flush_empty_read");

    wr(4'h8, 32'h0001_0002, 4'b0111);
    push(8'h61, 1'b0); push(8'h62, 1'b0);
    @(posedge clk_i); #1 check("pre_reset_irq", {31'h0, irq_o}, 32'h1);
    @(negedge clk_i);
    rx_valid_i = 1'b1; rx_byte_i = 8'h63;
    #2 reset = 1'b0;
    #1 check("midreset_irq", {31'h0, irq_o}, 32'h0);
    peek(4'h4, q); check("midreset_status", q, 32'h0001_0000);
    peek(4'h8, q); check("midreset_ctrl", q, 32'h0000_0001);
    rx_valid_i = 1'b0;
    sb.delete();
    @(negedge clk_i) reset = 1'b1;
    pop_chk("post_reset_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiver and the core data bus. Captures each byte strobed out of the UART deserializer into a DEPTH-entry FIFO, exposes it through a four-word memory-mapped window, and raises a level/timeout interrupt toward the core's external interrupt input (meip). Bus inputs arrive already registered by the top level, identical to the mtime and UART peripherals.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- SYS_CLK_FREQ, 60000000: clk_i frequency in Hz.
- BAUD, 9600: line rate; sets the timeout length.
- clk_i  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid_i  in  1  one-cycle strobe: rx_byte_i/rx_ferr_i valid.
- rx_byte_i  in  8  received byte.
- rx_ferr_i  in  1  frame (stop-bit) error for that byte.
- csb_i  in  1  chip select, active-low.
- wen_i  in  1  write enable, active-low (0 = write).
- addr_i  in  4  byte offset in window; [3:2] selects register.
- data_i  in  32  write data.
- wmask_i  in  4  byte write mask, bit n enables data_i[8n+7:8n].
- data_o  out  32  read data.
- irq_o  out  1  interrupt request, active-high.

## Operation
- Storage: DEPTH x 9 bits (byte + ferr); rd/wr pointers log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
- Push: rx_valid_i=1 and not full -> write at wr_ptr, wr_ptr+1, count+1. Full and no pop same cycle -> byte dropped, overrun set.
- Read access = csb_i=0, wen_i=1. Write access = csb_i=0, wen_i=0; register bits written only where wmask_i enables the byte.
- 0x0 DATA (read): [7:0] head byte, [8] head ferr, [31] empty. Non-empty read pops (rd_ptr+1, count-1). Empty read returns 0x8000_0000, no state change. Writes ignored.
- 0x4 STATUS: [8:0] count (zero-extended), [16] empty, [17] full, [18] overrun (sticky; write 1 with wmask_i[2] clears), [19] timeout pending (read-only).
- 0x8 CTRL: [8:0] threshold, reset 1; [16] level irq enable, reset 0; [17] timeout irq enable, reset 0; [24] flush, write-1 self-clearing, reads 0.
- 0xC: reads 0, writes ignored.
- Flush: pointers, count, timeout pending -> 0; overrun unchanged.
- Simultaneous events: push+pop when full -> both take effect, count stays DEPTH, no overrun. Push+pop when count=1 -> new byte becomes head. Flush with push -> flush wins, byte discarded, no overrun. Overrun set and cleared same cycle -> set wins.
- irq_o = (ctrl[16] & threshold!=0 & count>=threshold) | (ctrl[17] & timeout pending) | (ctrl[16] & overrun).
- Timeout: counter of cycles since last push or pop; cleared by push, pop, flush, or when empty. Reaching TO_CYCLES = 40*SYS_CLK_FREQ/BAUD (4 character times) while non-empty sets timeout pending; pending clears on DATA pop or flush.

## Timing
- data_o combinational from csb_i/addr_i and current state, same cycle as access; csb_i=1 -> data_o=0. Pop/register update at the closing clk_i edge.
- Every cycle with a qualifying DATA read counts as one pop; the bus holds an access for exactly one cycle.
- Pushed byte is readable the cycle after rx_valid_i.
- irq_o registered: asserts/deasserts one cycle after the causing condition changes.
- Reset: pointers, count, overrun, timeout pending, counter, ctrl[17:16] = 0; threshold = 1; irq_o = 0; data_o = 0. Reset mid-byte discards FIFO contents.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined: timeout counter, STATUS[19], CTRL[17] and their irq term implemented as above.
- Undefined: no counter logic; STATUS[19] and CTRL[17] read 0, writes ignored; irq_o has level and overrun terms only.

## Test plan
- Push 0x41,0x42,0x43; read DATA x3 -> 0x041,0x042,0x043; fourth read -> 0x8000_0000, count 0.
- Fill 16 bytes, push a 17th -> STATUS full=1, overrun=1, count 16; write STATUS 0x0004_0000 -> overrun 0.
- Threshold 4, ctrl[16]=1; push 3 bytes -> irq_o 0; 4th byte -> irq_o 1 next cycle; one pop -> irq_o 0 one cycle later.
- Full FIFO, push and DATA read same cycle -> oldest byte returned, count 16, overrun 0.
- Macro on, threshold 8, ctrl[17]=1; push 1 byte, idle TO_CYCLES -> STATUS[19]=1, irq_o 1; pop -> both 0.
- Push 5 bytes, write CTRL[24]=1 with concurrent rx_valid_i -> count 0, empty 1, threshold unchanged; assert reset mid-stream -> irq_o 0, count 0.
